ring_fifo: RTL and testbench

RING_FIFO -- requirements
Module: ring_fifo

---
 rtl/ring_fifo.sv | 142 ++++++++++++++
 tb/tb_ring_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_fifo.sv
// Single-clock circular-buffer FIFO with registered read data, registered
// occupancy flags and one-cycle overflow/underflow error pulses.
module ring_fifo #(
    parameter int unsigned FIFO_SIZE          = 8,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned ALMOST_FULL_LEVEL  = FIFO_SIZE - 1,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 1
) (
    input  logic                               clk,
    input  logic                               clear,
    input  logic                               flush,
    input  logic                               push,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               pop,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic                               out_valid,
    output logic [$clog2(FIFO_SIZE + 1)-1:0]   data_count,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int unsigned CW = $clog2(FIFO_SIZE + 1);
    localparam int unsigned PW = $clog2(FIFO_SIZE);

    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_SIZE - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_SIZE);
    localparam bit            AF_NEVER  = (ALMOST_FULL_LEVEL > FIFO_SIZE);
    localparam logic [CW-1:0] AF_CNT    = CW'(AF_NEVER ? FIFO_SIZE : ALMOST_FULL_LEVEL);
    localparam logic [CW-1:0] AE_CNT    =
        CW'((ALMOST_EMPTY_LEVEL > FIFO_SIZE) ? FIFO_SIZE : ALMOST_EMPTY_LEVEL);
    localparam bit            AF_AT_RST = (ALMOST_FULL_LEVEL == 0);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_SIZE];

    logic [PW-1:0]         wr_ptr_q,       wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q,       rd_ptr_d;
    logic [CW-1:0]         count_q,        count_d;
    logic                  full_q,         full_d;
    logic                  empty_q,        empty_d;
    logic                  almost_full_q,  almost_full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic [DATA_WIDTH-1:0] out_data_q,     out_data_d;
    logic                  out_valid_q,    out_valid_d;
    logic                  overflow_q,     overflow_d;
    logic                  underflow_q,    underflow_d;

    logic                  push_ok_c;
    logic                  pop_ok_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted alongside it; flush overrides both strobes.
    always_comb begin
        pop_ok_c       = pop && !flush && !empty_q;
        push_ok_c      = push && !flush && (!full_q || pop_ok_c);

        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        out_data_d     = out_data_q;
        out_valid_d    = pop_ok_c;
        overflow_d     = push && !flush && full_q && !pop_ok_c;
        underflow_d    = pop && !flush && empty_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok_c) begin
                out_data_d = mem_q[rd_ptr_q];
                rd_ptr_d   = ptr_inc(rd_ptr_q);
            end
            if (push_ok_c) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (push_ok_c && !pop_ok_c) begin
                count_d = count_q + CW'(1);
            end else if (pop_ok_c && !push_ok_c) begin
                count_d = count_q - CW'(1);
            end
        end

        full_d         = (count_d == FULL_CNT);
        empty_d        = (count_d == '0);
        almost_full_d  = !AF_NEVER && (count_d >= AF_CNT);
        almost_empty_d = (count_d <= AE_CNT);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= AF_AT_RST;
            almost_empty_q <= 1'b1;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // Storage has no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign data_count   = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_ring_fifo.sv
// Scoreboard bench for ring_fifo: a queue-based reference model predicts
// flags and pulses per cycle, read words are checked by a separate monitor.
module tb_ring_fifo;

    localparam int FS = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          clear;
    logic          flush;
    logic          push;
    logic [DW-1:0] in_data;
    logic          pop;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [2:0]    data_count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    ring_fifo #(
        .FIFO_SIZE          (FS),
        .DATA_WIDTH         (DW),
        .ALMOST_FULL_LEVEL  (3),
        .ALMOST_EMPTY_LEVEL (1)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .flush        (flush),
        .push         (push),
        .in_data      (in_data),
        .pop          (pop),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .data_count   (data_count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_out;
    logic [DW-1:0] mon_w;
    bit            e_valid;
    bit            e_ovf;
    bit            e_unf;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every out_valid pulse must carry the oldest outstanding word.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL mon_unexpected_valid: got out_valid=1 data %0h, required no output", out_data);
            end else begin
                mon_w = exp_q.pop_front();
                chk("mon_out_data", 32'(out_data), 32'(mon_w));
            end
        end
    end

    task automatic check_state();
        int n;
        n = model.size();
        chk("data_count",   32'(data_count),   32'(n));
        chk("full",         32'(full),         32'(n == FS));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("almost_full",  32'(almost_full),  32'(n >= 3));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 1));
        chk("overflow",     32'(overflow),     32'(e_ovf));
        chk("underflow",    32'(underflow),    32'(e_unf));
        chk("out_valid",    32'(out_valid),    32'(e_valid));
        chk("out_data",     32'(out_data),     32'(last_out));
    endtask

    // One clock of stimulus; the model decides what the edge must produce.
    task automatic step(input logic p, input logic [DW-1:0] d, input logic q, input logic f);
        bit pop_ok;
        bit push_ok;
        push    = p;
        in_data = d;
        pop     = q;
        flush   = f;
        if (f) begin
            model.delete();
            e_valid = 1'b0;
            e_ovf   = 1'b0;
            e_unf   = 1'b0;
        end else begin
            pop_ok  = q && (model.size() > 0);
            push_ok = p && ((model.size() < FS) || pop_ok);
            e_valid = pop_ok;
            e_ovf   = p && !push_ok;
            e_unf   = q && !pop_ok;
            if (pop_ok) begin
                last_out = model.pop_front();
                exp_q.push_back(last_out);
            end
            if (push_ok) begin
                model.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    // Clear lands between edges; its effect must be visible before the next edge.
    task automatic async_clear();
        #2;
        clear = 1'b1;
        #1;
        model.delete();
        exp_q.delete();
        last_out = '0;
        e_valid  = 1'b0;
        e_ovf    = 1'b0;
        e_unf    = 1'b0;
        check_state();
        @(posedge clk);
        #1;
        check_state();
        clear = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    initial begin
        bit p;
        bit q;
        bit f;
        int bias;

        clear    = 1'b1;
        flush    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        in_data  = '0;
        last_out = '0;
        e_valid  = 1'b0;
        e_ovf    = 1'b0;
        e_unf    = 1'b0;
        #3;
        check_state();
        @(posedge clk);
        #1;
        clear = 1'b0;
        check_state();

        // Fill to full, then overflow and drain in order.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        step(1, 8'h55, 0, 0);
        step(0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Alternating push/pop walks both pointers across the wrap point.
        for (int i = 0; i < 5; i++) begin
            step(1, 8'(8'h60 + i), 0, 0);
            step(0, 8'h00, 1, 0);
        end

        // Simultaneous push+pop at full, then at empty.
        for (int i = 0; i < 4; i++) step(1, 8'(8'h70 + i), 0, 0);
        for (int i = 0; i < 6; i++) step(1, 8'(8'h80 + i), 1, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
        step(1, 8'h9C, 1, 0);

        // Flush at count 3 (strobes ignored), then pop on empty.
        step(1, 8'hB1, 0, 0);
        step(1, 8'hB2, 0, 0);
        step(1, 8'h77, 1, 1);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Clear mid-burst; the first word after release must come back intact.
        step(1, 8'hC1, 0, 0);
        step(1, 8'hC2, 1, 0);
        step(1, 8'hC3, 1, 0);
        async_clear();
        step(1, 8'hA5, 0, 0);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 0);

        // Random traffic, alternating push-heavy and pop-heavy phases.
        for (int i = 0; i < 600; i++) begin
            bias = ((i / 75) % 2 == 0) ? 75 : 30;
            p = ($urandom_range(0, 99) < bias);
            q = ($urandom_range(0, 99) < (100 - bias));
            f = ($urandom_range(0, 49) == 0);
            step(p, 8'($urandom), q, f);
        end

        step(0, 8'h00, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
